// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int MASK_W   = 4;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational grant decision for the data-memory arbiter.
// DMEM_ARB_RR_EN selects strict alternation; otherwise fixed core priority with a starvation limit.
module dmem_arb_sel
  import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input  logic                core_req,
  input  logic                ext_req,
`ifdef DMEM_ARB_RR_EN
  input  logic [1:0]          owner_q,
`else
  input  logic [STARVE_W-1:0] starve_q,
`endif
  output logic                core_gnt,
  output logic                ext_gnt
);

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (core_req && ext_req) begin
`ifdef DMEM_ARB_RR_EN
      // Alternate against the last grantee; no history means the core goes first.
      if (owner_q == OWN_CORE) begin
        ext_gnt = 1'b1;
      end else begin
        core_gnt = 1'b1;
      end
`else
      if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
        ext_gnt = 1'b1;
      end else begin
        core_gnt = 1'b1;
      end
`endif
    end else begin
      core_gnt = core_req;
      ext_gnt  = ext_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data memory between the core LSU port and an external requester.
// Build option: DMEM_ARB_RR_EN switches contested cycles to strict round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [MASK_W-1:0] core_mask_i,
  input  logic [AW-1:0]     core_addr_i,
  input  logic [DW-1:0]     core_wdata_i,
  output logic [DW-1:0]     core_rdata_o,
  output logic              core_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [MASK_W-1:0] ext_mask_i,
  input  logic [AW-1:0]     ext_addr_i,
  input  logic [DW-1:0]     ext_wdata_i,
  output logic              ext_gnt_o,
  output logic [DW-1:0]     ext_rdata_o,
  output logic              ext_rvalid_o,
  output logic              mem_we_o,
  output logic [MASK_W-1:0] mem_mask_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic [DW-1:0]     mem_rdata_i
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be within 1..15");
  end

  logic   core_req;
  logic   ext_req;
  logic   core_gnt;
  logic   ext_gnt;
  owner_e owner_q;
  owner_e owner_d;
  logic   ext_we_p1;
  logic [DW-1:0] ext_rdata_p1;

  // Requests are masked during reset so every combinational output sits idle.
  assign core_req = core_req_i & ~rst_i;
  assign ext_req  = ext_req_i & ~rst_i;

`ifdef DMEM_ARB_RR_EN
  dmem_arb_sel u_sel (
    .core_req (core_req),
    .ext_req  (ext_req),
    .owner_q  (owner_q),
    .core_gnt (core_gnt),
    .ext_gnt  (ext_gnt)
  );
`else
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  dmem_arb_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .core_req (core_req),
    .ext_req  (ext_req),
    .starve_q (starve_q),
    .core_gnt (core_gnt),
    .ext_gnt  (ext_gnt)
  );

  // With ext still requesting and not granted, the core must have won a contested cycle.
  always_comb begin
    starve_d = starve_q;
    if (!ext_req || ext_gnt) begin
      starve_d = '0;
    end else if (core_gnt && starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    owner_d = OWN_NONE;
    if (core_gnt) begin
      owner_d = OWN_CORE;
    end else if (ext_gnt) begin
      owner_d = OWN_EXT;
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_mask_o  = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_gnt) begin
      mem_we_o    = core_we_i;
      mem_mask_o  = core_mask_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (ext_gnt) begin
      mem_we_o    = ext_we_i;
      mem_mask_o  = ext_mask_i;
      mem_addr_o  = ext_addr_i;
      mem_wdata_o = ext_wdata_i;
    end
  end

  assign core_rdata_o = core_gnt ? mem_rdata_i : '0;
  assign core_stall_o = core_req & ~core_gnt;
  assign ext_gnt_o    = ext_gnt;

  // Stage p1: grant owner and captured ext read data, one cycle after the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= OWN_NONE;
      ext_we_p1    <= 1'b0;
      ext_rdata_p1 <= '0;
    end else begin
      owner_q <= owner_d;
      if (ext_gnt) begin
        ext_we_p1 <= ext_we_i;
      end
      if (ext_gnt && !ext_we_i) begin
        ext_rdata_p1 <= mem_rdata_i;
      end
    end
  end

  // A read completes exactly when the previous cycle's grantee was ext doing a read.
  assign ext_rvalid_o = (owner_q == OWN_EXT) & ~ext_we_p1;
  assign ext_rdata_o  = ext_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter with a spec-level reference model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [3:0]  core_mask;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [3:0]  ext_mask;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic        init_mem;
  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];

  int          m_losses;
  int          m_last;
  logic        exp_rv;
  logic [31:0] exp_rd;
  logic        mc, me;
  logic        last_gnt, last_stall;
  logic [31:0] last_crd;

  dmem_arbiter #(.DW(32), .AW(32), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_mask_i(core_mask),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_rdata_o(core_rdata),
    .core_stall_o(core_stall),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_mask_i(ext_mask),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt),
    .ext_rdata_o(ext_rdata), .ext_rvalid_o(ext_rvalid),
    .mem_we_o(mem_we), .mem_mask_o(mem_mask), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  function automatic int idx(logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Data memory the arbiter drives: combinational read, masked write on the clock edge.
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) dmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_reset();
    m_losses = 0;
    m_last   = 0;
    exp_rv   = 1'b0;
    exp_rd   = 32'h0;
  endtask

  // One arbitration cycle: drive, check the combinational response, then the registered one.
  task automatic step(input logic c_req, input logic c_we, input logic [3:0] c_mask,
                      input logic [31:0] c_addr, input logic [31:0] c_wdata,
                      input logic e_req, input logic e_we, input logic [3:0] e_mask,
                      input logic [31:0] e_addr, input logic [31:0] e_wdata);
    logic        x_we;
    logic [3:0]  x_mask;
    logic [31:0] x_addr, x_wdata;
    @(negedge clk);
    core_req = c_req; core_we = c_we; core_mask = c_mask; core_addr = c_addr; core_wdata = c_wdata;
    ext_req  = e_req; ext_we  = e_we; ext_mask  = e_mask; ext_addr  = e_addr; ext_wdata  = e_wdata;
    #1;
    if (c_req && e_req) begin
`ifdef DMEM_ARB_RR_EN
      me = (m_last == 1);
`else
      me = (m_losses == LIMIT);
`endif
      mc = !me;
    end else begin
      mc = c_req;
      me = e_req;
    end
    x_we = 1'b0; x_mask = 4'h0; x_addr = 32'h0; x_wdata = 32'h0;
    if (mc) begin
      x_we = c_we; x_mask = c_mask; x_addr = c_addr; x_wdata = c_wdata;
    end else if (me) begin
      x_we = e_we; x_mask = e_mask; x_addr = e_addr; x_wdata = e_wdata;
    end
    chk("ext_gnt",    32'(ext_gnt),    32'(me));
    chk("core_stall", 32'(core_stall), 32'(c_req && !mc));
    chk("mem_we",     32'(mem_we),     32'(x_we));
    chk("mem_mask",   32'(mem_mask),   32'(x_mask));
    chk("mem_addr",   mem_addr,        x_addr);
    chk("mem_wdata",  mem_wdata,       x_wdata);
    if (mc && !c_we) chk("core_rdata", core_rdata, ref_mem[idx(c_addr)]);
    last_gnt = ext_gnt; last_stall = core_stall; last_crd = core_rdata;
    @(posedge clk);
    #1;
    if (me && !e_we) begin
      exp_rv = 1'b1;
      exp_rd = ref_mem[idx(e_addr)];
    end else begin
      exp_rv = 1'b0;
    end
    if (mc && c_we) ref_write(c_addr, c_wdata, c_mask);
    else if (me && e_we) ref_write(e_addr, e_wdata, e_mask);
    if (!e_req || me) m_losses = 0;
    else if (m_losses < LIMIT) m_losses++;
    m_last = mc ? 1 : (me ? 2 : 0);
    chk("ext_rvalid", 32'(ext_rvalid), 32'(exp_rv));
    chk("ext_rdata",  ext_rdata,       exp_rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pe_req, pe_we;
    logic [3:0]  pe_mask;
    logic [31:0] pe_addr, pe_wdata;
    logic        rc_req, rc_we;

    // Reset with both ports requesting writes: everything must stay idle.
    rst = 1'b1; init_mem = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_mask = 4'hF; core_addr = 32'h10; core_wdata = 32'h1;
    ext_req  = 1'b1; ext_we  = 1'b1; ext_mask  = 4'hF; ext_addr  = 32'h20; ext_wdata  = 32'h2;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ext_gnt",    32'(ext_gnt),    32'h0);
    chk("rst_core_stall", 32'(core_stall), 32'h0);
    chk("rst_mem_we",     32'(mem_we),     32'h0);
    chk("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
    chk("rst_ext_rdata",  ext_rdata,       32'h0);
    @(negedge clk);
    rst = 1'b0; init_mem = 1'b0;
    core_req = 1'b0; ext_req = 1'b0;

    // Core-only load of 0x10.
    step(1, 0, 4'hF, 32'h10, 0, 0, 0, 4'h0, 0, 0);
    chk("t1_rdata", last_crd, 32'hDEADBEEF);
    chk("t1_stall", 32'(last_stall), 32'h0);

    // Ext-only write then read back.
    step(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h20, 32'h12345678);
    chk("t2_wr_gnt", 32'(last_gnt), 32'h1);
    step(0, 0, 4'h0, 0, 0, 1, 0, 4'hF, 32'h20, 0);
    chk("t2_rd_gnt", 32'(last_gnt), 32'h1);
    chk("t2_rvalid", 32'(ext_rvalid), 32'h1);
    chk("t2_rdata",  ext_rdata, 32'h12345678);

    // Continuous contention.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 4'hF, 32'(i * 4), 0, 1, 0, 4'hF, 32'h20, 0);
`ifdef DMEM_ARB_RR_EN
      chk("t3_rr_gnt",    32'(last_gnt),   32'(i % 2 == 1));
      chk("t3_rr_stall",  32'(last_stall), 32'(i % 2 == 1));
`else
      chk("t3_fix_gnt",   32'(last_gnt),   32'(i % 5 == 4));
      chk("t3_fix_stall", 32'(last_stall), 32'(i % 5 == 4));
`endif
    end

    // Ext drops after two contested losses, then re-raises.
    step(1, 0, 4'hF, 32'h40, 0, 1, 0, 4'hF, 32'h24, 0);
    step(1, 0, 4'hF, 32'h44, 0, 1, 0, 4'hF, 32'h24, 0);
    step(1, 0, 4'hF, 32'h48, 0, 0, 0, 4'h0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 4'hF, 32'h50, 0, 1, 0, 4'hF, 32'h28, 0);
`ifndef DMEM_ARB_RR_EN
      chk("t6_gnt", 32'(last_gnt), 32'(k == 4));
`endif
    end

    // Ext read granted, reset lands in the rvalid cycle.
    step(0, 0, 4'h0, 0, 0, 1, 0, 4'hF, 32'h20, 0);
    chk("t5_pre_rvalid", 32'(ext_rvalid), 32'h1);
    core_req = 1'b1; core_we = 1'b1; ext_we = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("t5_rvalid",  32'(ext_rvalid), 32'h0);
    chk("t5_mem_we",  32'(mem_we),     32'h0);
    chk("t5_ext_gnt", 32'(ext_gnt),    32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; core_req = 1'b0; ext_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 4'hF, 32'h60, 0, 1, 0, 4'hF, 32'h2C, 0);
`ifdef DMEM_ARB_RR_EN
      chk("t5_post_gnt", 32'(last_gnt), 32'(k % 2 == 1));
`else
      chk("t5_post_gnt", 32'(last_gnt), 32'(k == 4));
`endif
    end
    step(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Randomized traffic; ext holds its request until granted, with occasional drops.
    pe_req = 1'b0; pe_we = 1'b0; pe_mask = 4'h0; pe_addr = 0; pe_wdata = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pe_req) begin
        pe_req = ($urandom_range(0, 2) == 0);
        pe_we = $urandom_range(0, 1) == 1;
        pe_mask = 4'($urandom);
        pe_addr = 32'($urandom_range(0, 63)) << 2;
        pe_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        pe_req = 1'b0;
      end
      rc_req = $urandom_range(0, 1) == 1;
      rc_we  = $urandom_range(0, 9) < 3;
      step(rc_req, rc_we, 4'($urandom), 32'($urandom_range(0, 63)) << 2, $urandom,
           pe_req, pe_we, pe_mask, pe_addr, pe_wdata);
      if (last_gnt) pe_req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
